// File: rtl/pic_pkg.sv
// Shared definitions for the programmable interrupt controller.
//   state_e     : controller state (IDLE / BUSY)
//   id_width()  : cause-ID width for a given number of sources
//   SRC_TIMER / SRC_EXT : default source slot assignments
package pic_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int unsigned SRC_TIMER = 0;
    localparam int unsigned SRC_EXT   = 1;

    // Width of the cause ID; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// Lowest-index-wins priority encoder (source 0 has the highest priority).
//   req    : request vector
//   valid  : any request present
//   id     : index of the winning request (0 when none)
//   onehot : one-hot of the winning request (0 when none)
module pic_prio_enc #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = 3
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    id,
    output logic [NUM_SRC-1:0] onehot
);

    // Two's-complement trick isolates the lowest set bit.
    assign valid  = |req;
    assign onehot = req & (~req + NUM_SRC'(1));

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/pic_n.sv
// Programmable interrupt controller, NUM_SRC sources, one interrupt in flight.
// Inputs:
//   clk, resetn      : core clock, asynchronous active-low reset
//   src_sync         : synchronised interrupt sources
//   src_en, glb_ie   : per-source and global enables from CSR
//   vld_d            : valid instruction in decode (interrupts taken only then)
//   ertn_w           : ertn retiring in writeback, ends the in-progress interrupt
//   ovf_clr          : clears all lost_edge flags
// Outputs:
//   intr_sync        : interrupt request toward decode (take | busy)
//   intr_sync_pulse  : one-cycle pulse in the take cycle
//   intr_id          : cause ID of the taken / in-progress source
//   intr_vec         : one-hot of the taken / in-progress source
//   pend             : raw pending vector
//   lost_edge        : sticky, an edge arrived while that source was already pending
module pic_n
    import pic_pkg::*;
#(
    parameter int unsigned          NUM_SRC   = 8,
    parameter int unsigned          ID_W      = id_width(NUM_SRC),
    parameter logic [NUM_SRC-1:0]   EDGE_MASK = NUM_SRC'(1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_SRC-1:0] src_sync,
    input  logic [NUM_SRC-1:0] src_en,
    input  logic               glb_ie,
    input  logic               vld_d,
    input  logic               ertn_w,
    input  logic               ovf_clr,
    output logic               intr_sync,
    output logic               intr_sync_pulse,
    output logic [ID_W-1:0]    intr_id,
    output logic [NUM_SRC-1:0] intr_vec,
    output logic [NUM_SRC-1:0] pend,
    output logic [NUM_SRC-1:0] lost_edge
);

    state_e               state_q;
    state_e               state_nxt;
    logic [NUM_SRC-1:0]   prev_q;
    logic [NUM_SRC-1:0]   pend_q;
    logic [NUM_SRC-1:0]   pend_nxt;
    logic [NUM_SRC-1:0]   lost_nxt;
    logic [ID_W-1:0]      intr_id_q;

    logic [NUM_SRC-1:0]   rise;
    logic [NUM_SRC-1:0]   cand;
    logic                 cand_valid;
    logic [ID_W-1:0]      win_id;
    logic [NUM_SRC-1:0]   win_vec;
    logic                 busy;
    logic                 take;
    logic [NUM_SRC-1:0]   take_vec;
    logic [NUM_SRC-1:0]   busy_vec;

    // Edge detect only matters for edge-mode sources.
    assign rise = src_sync & ~prev_q & EDGE_MASK;

    // Edge sources come from the latch, level sources straight from the pin.
    assign pend = (pend_q & EDGE_MASK) | (src_sync & ~EDGE_MASK);
    assign cand = glb_ie ? (pend & src_en) : '0;

    pic_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req    (cand),
        .valid  (cand_valid),
        .id     (win_id),
        .onehot (win_vec)
    );

    assign busy     = (state_q == BUSY);
    assign take     = ~busy & cand_valid & vld_d & ~ertn_w;
    assign take_vec = take ? win_vec : '0;
    assign busy_vec = NUM_SRC'(1) << intr_id_q;

    // Request and cause outputs: winner during the take cycle, latched ID while busy.
    assign intr_sync       = take | busy;
    assign intr_sync_pulse = take;
    assign intr_id         = take ? win_id  : (busy ? intr_id_q : '0);
    assign intr_vec        = take ? win_vec : (busy ? busy_vec  : '0);

    // Next-state and latch updates; a coincident rise beats the take clear and ovf_clr.
    always_comb begin
        state_nxt = state_q;
        pend_nxt  = (rise | (pend_q & ~take_vec)) & EDGE_MASK;
        lost_nxt  = (lost_edge & ~{NUM_SRC{ovf_clr}}) | (rise & pend_q & ~take_vec);
        case (state_q)
            IDLE:    if (take)   state_nxt = BUSY;
            BUSY:    if (ertn_w) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_q    <= '0;
            pend_q    <= '0;
            lost_edge <= '0;
            intr_id_q <= '0;
        end else begin
            prev_q    <= src_sync;
            pend_q    <= pend_nxt;
            lost_edge <= lost_nxt;
            if (take) begin
                intr_id_q <= win_id;
            end
        end
    end

endmodule

// File: tb/tb_pic_n.sv
// Directed bench for pic_n. Sources 0,1,2,3,5 are edge-mode; 4,6,7 are level-mode.
module tb_pic_n;

    localparam int unsigned NUM_SRC = 8;
    localparam int unsigned ID_W    = 3;
    localparam logic [7:0]  EMASK   = 8'b0010_1111;

    logic         clk = 1'b0;
    logic         resetn;
    logic [7:0]   src_sync;
    logic [7:0]   src_en;
    logic         glb_ie;
    logic         vld_d;
    logic         ertn_w;
    logic         ovf_clr;
    logic         intr_sync;
    logic         intr_sync_pulse;
    logic [2:0]   intr_id;
    logic [7:0]   intr_vec;
    logic [7:0]   pend;
    logic [7:0]   lost_edge;

    int checks = 0;
    int errors = 0;

    pic_n #(
        .NUM_SRC   (NUM_SRC),
        .ID_W      (ID_W),
        .EDGE_MASK (EMASK)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .src_sync        (src_sync),
        .src_en          (src_en),
        .glb_ie          (glb_ie),
        .vld_d           (vld_d),
        .ertn_w          (ertn_w),
        .ovf_clr         (ovf_clr),
        .intr_sync       (intr_sync),
        .intr_sync_pulse (intr_sync_pulse),
        .intr_id         (intr_id),
        .intr_vec        (intr_vec),
        .pend            (pend),
        .lost_edge       (lost_edge)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; checks follow 1ns later.
    task automatic step;
        @(negedge clk);
    endtask

    // Interrupt-facing outputs in one call.
    task automatic chk_intr(input string tag, input logic s, input logic p,
                            input logic [2:0] id, input logic [7:0] vec);
        chk({tag, ".sync"},  32'(intr_sync),       32'(s));
        chk({tag, ".pulse"}, 32'(intr_sync_pulse), 32'(p));
        chk({tag, ".id"},    32'(intr_id),         32'(id));
        chk({tag, ".vec"},   32'(intr_vec),        32'(vec));
    endtask

    initial begin
        resetn = 1'b0; src_sync = '0; src_en = '0; glb_ie = 1'b0;
        vld_d = 1'b0; ertn_w = 1'b0; ovf_clr = 1'b0;
        step; step; #1;
        chk_intr("rst", 1'b0, 1'b0, 3'd0, 8'h00);
        chk("rst.pend", 32'(pend), 32'h0);
        chk("rst.lost", 32'(lost_edge), 32'h0);

        step; resetn = 1'b1; src_en = 8'hFF; glb_ie = 1'b1; vld_d = 1'b1;
        step;

        // Single edge source 0: pend latches on rise, take next cycle.
        step; src_sync = 8'h01; #1;
        chk_intr("e0.rise", 1'b0, 1'b0, 3'd0, 8'h00);
        step; #1;
        chk_intr("e0.take", 1'b1, 1'b1, 3'd0, 8'h01);
        chk("e0.take.pend", 32'(pend), 32'h01);
        step; src_sync = 8'h00; #1;
        chk_intr("e0.busy", 1'b1, 1'b0, 3'd0, 8'h01);
        chk("e0.busy.pend", 32'(pend), 32'h00);
        step; ertn_w = 1'b1; #1;
        chk("e0.ertn.sync", 32'(intr_sync), 32'h1);
        step; ertn_w = 1'b0; #1;
        chk_intr("e0.idle", 1'b0, 1'b0, 3'd0, 8'h00);

        // Priority: 5 and 2 together, 2 wins, then 5 once vld_d returns.
        step; src_sync = 8'h24;
        step; src_sync = 8'h00; #1;
        chk_intr("pr.take2", 1'b1, 1'b1, 3'd2, 8'h04);
        chk("pr.take2.pend", 32'(pend), 32'h24);
        step; #1;
        chk("pr.busy.pend", 32'(pend), 32'h20);
        step; ertn_w = 1'b1; #1;
        chk_intr("pr.ertn", 1'b1, 1'b0, 3'd2, 8'h04);
        step; ertn_w = 1'b0; vld_d = 1'b0; #1;
        chk_intr("pr.novld", 1'b0, 1'b0, 3'd0, 8'h00);
        step; vld_d = 1'b1; #1;
        chk_intr("pr.take5", 1'b1, 1'b1, 3'd5, 8'h20);
        step; ertn_w = 1'b1;
        step; ertn_w = 1'b0; #1;
        chk("pr.idle.pend", 32'(pend), 32'h00);
        chk("pr.idle.sync", 32'(intr_sync), 32'h0);

        // Gating: glb_ie, vld_d, then ertn_w suppressing the take.
        step; glb_ie = 1'b0; src_sync = 8'h02;
        step; src_sync = 8'h00; #1;
        chk("gt.glb.pend", 32'(pend), 32'h02);
        chk("gt.glb.sync", 32'(intr_sync), 32'h0);
        step; glb_ie = 1'b1; vld_d = 1'b0; #1;
        chk("gt.vld.sync", 32'(intr_sync), 32'h0);
        step; vld_d = 1'b1; ertn_w = 1'b1; #1;
        chk("gt.ertn.sync", 32'(intr_sync), 32'h0);
        step; ertn_w = 1'b0; #1;
        chk_intr("gt.take1", 1'b1, 1'b1, 3'd1, 8'h02);
        step; ertn_w = 1'b1;
        step; ertn_w = 1'b0; #1;
        chk("gt.idle.pend", 32'(pend), 32'h00);

        // Lost edge on src0 while busy with src3; then back-to-back take of src0.
        step; src_sync = 8'h08;
        step; src_sync = 8'h00; #1;
        chk_intr("le.take3", 1'b1, 1'b1, 3'd3, 8'h08);
        step; src_sync = 8'h01; #1;
        chk("le.first.lost", 32'(lost_edge), 32'h00);
        step; src_sync = 8'h00; #1;
        chk("le.first.pend", 32'(pend), 32'h01);
        step; src_sync = 8'h01;
        step; src_sync = 8'h00; #1;
        chk("le.second.lost", 32'(lost_edge), 32'h01);
        chk_intr("le.still_busy", 1'b1, 1'b0, 3'd3, 8'h08);
        step; ovf_clr = 1'b1; #1;
        chk("le.clr.lost_hold", 32'(lost_edge), 32'h01);
        step; ovf_clr = 1'b0; #1;
        chk("le.clr.lost", 32'(lost_edge), 32'h00);
        step; ertn_w = 1'b1;
        step; ertn_w = 1'b0; #1;
        chk_intr("le.b2b", 1'b1, 1'b1, 3'd0, 8'h01);
        step; ertn_w = 1'b1; #1;
        chk("le.b2b.pend", 32'(pend), 32'h00);
        step; ertn_w = 1'b0;

        // Level source 4: taken at once, retaken after ertn, drop clears pend.
        step; src_sync = 8'h10; #1;
        chk_intr("lv.take", 1'b1, 1'b1, 3'd4, 8'h10);
        step; ertn_w = 1'b1; #1;
        chk("lv.busy.pend", 32'(pend), 32'h10);
        chk("lv.busy.pulse", 32'(intr_sync_pulse), 32'h0);
        step; ertn_w = 1'b0; #1;
        chk_intr("lv.retake", 1'b1, 1'b1, 3'd4, 8'h10);
        step; ertn_w = 1'b1;
        step; ertn_w = 1'b0; vld_d = 1'b0; src_sync = 8'h00; #1;
        chk("lv.drop.pend", 32'(pend), 32'h00);
        step; vld_d = 1'b1; #1;
        chk("lv.drop.sync", 32'(intr_sync), 32'h0);

        // Per-source enable masks level src6; disabling while busy does not abort.
        step; src_en = 8'hBF; src_sync = 8'h40; #1;
        chk("en.mask.pend", 32'(pend), 32'h40);
        chk("en.mask.sync", 32'(intr_sync), 32'h0);
        step; src_en = 8'hFF; #1;
        chk_intr("en.take6", 1'b1, 1'b1, 3'd6, 8'h40);
        step; src_en = 8'h00; glb_ie = 1'b0; src_sync = 8'h00; #1;
        chk_intr("en.busy_off", 1'b1, 1'b0, 3'd6, 8'h40);
        step; ertn_w = 1'b1;
        step; ertn_w = 1'b0; src_en = 8'hFF; glb_ie = 1'b1; #1;
        chk("en.idle.sync", 32'(intr_sync), 32'h0);

        // Reset mid-busy with src3 pending.
        step; src_sync = 8'h20;
        step; src_sync = 8'h00; #1;
        chk_intr("rb.take5", 1'b1, 1'b1, 3'd5, 8'h20);
        step; src_sync = 8'h08;
        step; src_sync = 8'h00; #1;
        chk("rb.pend", 32'(pend), 32'h08);
        resetn = 1'b0; #1;
        chk_intr("rb.rst", 1'b0, 1'b0, 3'd0, 8'h00);
        chk("rb.rst.pend", 32'(pend), 32'h00);
        chk("rb.rst.lost", 32'(lost_edge), 32'h00);
        step; resetn = 1'b1; #1;
        chk_intr("rb.rel", 1'b0, 1'b0, 3'd0, 8'h00);
        step; #1;
        chk("rb.rel2.pulse", 32'(intr_sync_pulse), 32'h0);
        chk("rb.rel2.pend", 32'(pend), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
